uart_word_tx: RTL and testbench

UART_WORD_TX -- requirements
Module: uart_word_tx

---
 rtl/uart_word_tx.sv | 166 ++++++++++++++++
 tb/tb_uart_word_tx.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_tx.sv
// ---------------------------------------------------------------------------
// uart_word_tx
//
// Splits a BITS_SIZE-bit word from the debug unit into SIZE_TRAMA-bit frames.
// It hands the frames one at a time to a byte-wide UART transmitter, using a
// start/done handshake.
//
// Parameters
//   BITS_SIZE  : width of the word accepted for transmission.
//   SIZE_TRAMA : UART payload width. BITS_SIZE must be a multiple of it.
//   MSB_FIRST  : 0 = send the least-significant byte first,
//                1 = send the most-significant byte first.
//
// Ports
//   i_clk           : single clock (shared with the UART and the debug unit)
//   i_reset         : asynchronous reset, active low
//   i_word_valid    : a word is available on i_word
//   i_word          : word to transmit
//   o_word_ready    : block is idle and will accept i_word_valid
//   i_abort         : cancel the word in progress (ignored while idle,
//                     except that it also rejects a word offered while idle)
//   o_uart_tx_start : one-cycle start pulse to the UART transmitter
//   o_uart_tx_data  : byte presented to the UART transmitter
//   i_uart_tx_done  : one-cycle pulse when the UART has finished a frame
//   o_busy          : high whenever a word is in progress
//   o_word_done     : one-cycle pulse after the last byte of a word is sent
// ---------------------------------------------------------------------------
module uart_word_tx #(
  parameter int BITS_SIZE  = 32,
  parameter int SIZE_TRAMA = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_word_valid,
  input  logic [BITS_SIZE-1:0]  i_word,
  output logic                  o_word_ready,
  input  logic                  i_abort,
  output logic                  o_uart_tx_start,
  output logic [SIZE_TRAMA-1:0] o_uart_tx_data,
  input  logic                  i_uart_tx_done,
  output logic                  o_busy,
  output logic                  o_word_done
);

  // Number of frames per word. The counter is at least one bit wide, so the
  // single-frame case (N = 1) still has a legal counter.
  localparam int N  = BITS_SIZE / SIZE_TRAMA;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                 state_reg,  state_next;
  logic [CW-1:0]          cnt_reg,    cnt_next;
  logic [BITS_SIZE-1:0]   word_reg,   word_next;

  // The latched word, viewed as an array of frames. Frame k is
  // word_reg[k*SIZE_TRAMA +: SIZE_TRAMA].
  logic [SIZE_TRAMA-1:0]  byte_arr [N];
  logic [CW-1:0]          byte_sel;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_byte_split
      assign byte_arr[gi] = word_reg[gi*SIZE_TRAMA +: SIZE_TRAMA];
    end
  endgenerate

  // The counter always runs 0..N-1. The transmit order is set only by how
  // the counter is mapped onto a frame index.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign byte_sel = LAST_IDX - cnt_reg;
    end else begin : g_lsb_first
      assign byte_sel = cnt_reg;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State, counter and word registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      word_reg  <= word_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    word_next  = word_reg;

    case (state_reg)
      IDLE: begin
        // An abort that coincides with a new word rejects that word.
        if (i_word_valid && !i_abort) begin
          word_next  = i_word;
          cnt_next   = '0;
          state_next = SEND;
        end
      end

      SEND: begin
        if (i_abort) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        // An abort wins over a tx_done that arrives in the same cycle.
        if (i_abort) begin
          state_next = IDLE;
        end else if (i_uart_tx_done) begin
          if (cnt_reg == LAST_IDX) begin
            state_next = DONE;
          end else begin
            cnt_next   = cnt_reg + 1'b1;
            state_next = SEND;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // All outputs are decoded from registered state. Because of this, an
  // asynchronous reset takes them to their idle values immediately, without
  // waiting for a clock edge.
  //
  // The frame on o_uart_tx_data is a function of word_reg and cnt_reg only.
  // Neither register changes between SEND and the tx_done that ends WAIT, so
  // the data stays stable for the whole UART frame.
  assign o_word_ready    = (state_reg == IDLE);
  assign o_busy          = (state_reg != IDLE);
  assign o_uart_tx_start = (state_reg == SEND);
  assign o_word_done     = (state_reg == DONE);
  assign o_uart_tx_data  = byte_arr[byte_sel];

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] word;
  logic        abort;
  logic        tx_done;

  logic        ready0, start0, busy0, wdone0;
  logic [7:0]  data0;
  logic        ready1, start1, busy1, wdone1;
  logic [7:0]  data1;

  int checks = 0;
  int errors = 0;
  int start_cnt0 = 0;
  int start_cnt1 = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  logic [7:0] last0 = 8'h00;
  logic [7:0] last1 = 8'h00;

  // Expected frames. q0 holds LSB-first order, q1 holds MSB-first order.
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  // Both instances receive identical stimulus and differ only in frame order.
  uart_word_tx #(.BITS_SIZE(32), .SIZE_TRAMA(8), .MSB_FIRST(1'b0)) dut_lsb (
    .i_clk(clk), .i_reset(rst_n), .i_word_valid(valid), .i_word(word),
    .o_word_ready(ready0), .i_abort(abort), .o_uart_tx_start(start0),
    .o_uart_tx_data(data0), .i_uart_tx_done(tx_done), .o_busy(busy0),
    .o_word_done(wdone0)
  );

  uart_word_tx #(.BITS_SIZE(32), .SIZE_TRAMA(8), .MSB_FIRST(1'b1)) dut_msb (
    .i_clk(clk), .i_reset(rst_n), .i_word_valid(valid), .i_word(word),
    .o_word_ready(ready1), .i_abort(abort), .o_uart_tx_start(start1),
    .o_uart_tx_data(data1), .i_uart_tx_done(tx_done), .o_busy(busy1),
    .o_word_done(wdone1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) begin
      q0.push_back(w[k*8 +: 8]);
      q1.push_back(w[(3-k)*8 +: 8]);
    end
  endfunction

  // Scoreboard: every start pulse pops one expected frame. While a frame is
  // in flight, the data must hold the value presented at its start.
  always @(negedge clk) begin
    if (start0) begin
      start_cnt0++;
      chk("sb0_pending", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) chk("sb0_byte", 32'(data0), 32'(q0.pop_front()));
      last0 = data0;
    end else if (busy0 && !wdone0) begin
      chk("hold0", 32'(data0), 32'(last0));
    end
    if (start1) begin
      start_cnt1++;
      chk("sb1_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) chk("sb1_byte", 32'(data1), 32'(q1.pop_front()));
      last1 = data1;
    end else if (busy1 && !wdone1) begin
      chk("hold1", 32'(data1), 32'(last1));
    end
    if (wdone0) done_cnt0++;
    if (wdone1) done_cnt1++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a word while idle. Acceptance must produce a start at cycle 1.
  task automatic send_word(input logic [31:0] w);
    valid = 1'b1;
    word  = w;
    push_word(w);
    tick();
    valid = 1'b0;
    chk("accept_start0", 32'(start0), 32'd1);
    chk("accept_start1", 32'(start1), 32'd1);
    chk("accept_busy", 32'(busy0), 32'd1);
    chk("accept_ready", 32'(ready0), 32'd0);
  endtask

  // Wait (bounded) until a start pulse is visible at a falling edge.
  task automatic wait_start();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (start0) seen = 1'b1;
    end
    chk("start_seen", 32'(seen), 32'd1);
  endtask

  // Called at the falling edge inside SEND. Returns 1ps after the edge at
  // which the done pulse was sampled, "dly" edges after the start edge.
  task automatic pulse_done(input int dly);
    @(posedge clk);
    #1;
    repeat (dly - 1) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic run_bytes(input int n, input int dly);
    for (int i = 0; i < n; i++) begin
      wait_start();
      pulse_done(dly);
    end
  endtask

  // Called right after the last done has been sampled.
  task automatic finish_word();
    chk("word_done0", 32'(wdone0), 32'd1);
    chk("word_done1", 32'(wdone1), 32'd1);
    chk("done_no_start", 32'(start0), 32'd0);
    tick();
    chk("idle_ready", 32'(ready0), 32'd1);
    chk("idle_busy", 32'(busy0), 32'd0);
    chk("idle_wdone", 32'(wdone0), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready0"}, 32'(ready0), 32'd1);
    chk({tag, "_busy0"}, 32'(busy0), 32'd0);
    chk({tag, "_start0"}, 32'(start0), 32'd0);
    chk({tag, "_data0"}, 32'(data0), 32'd0);
    chk({tag, "_wdone0"}, 32'(wdone0), 32'd0);
    chk({tag, "_data1"}, 32'(data1), 32'd0);
    chk({tag, "_busy1"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s0, s1, d0;
    rst_n   = 1'b0;
    valid   = 1'b0;
    word    = '0;
    abort   = 1'b0;
    tx_done = 1'b0;

    // Reset state
    #3;
    chk_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Word 0x12345678: LSB-first gives 78 56 34 12, MSB-first 12 34 56 78
    s0 = start_cnt0; s1 = start_cnt1; d0 = done_cnt0;
    send_word(32'h1234_5678);
    run_bytes(4, 1);
    finish_word();
    chk("w1_starts0", 32'(start_cnt0 - s0), 32'd4);
    chk("w1_starts1", 32'(start_cnt1 - s1), 32'd4);
    chk("w1_dones", 32'(done_cnt0 - d0), 32'd1);

    // Word 0xDEADBEEF: MSB-first gives DE AD BE EF
    s0 = start_cnt0; d0 = done_cnt0;
    send_word(32'hDEAD_BEEF);
    run_bytes(4, 2);
    finish_word();
    chk("w2_starts", 32'(start_cnt0 - s0), 32'd4);
    chk("w2_dones", 32'(done_cnt0 - d0), 32'd1);

    // A tx_done while idle must do nothing
    s0 = start_cnt0; d0 = done_cnt0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("idle_done_busy", 32'(busy0), 32'd0);
    chk("idle_done_start", 32'(start0), 32'd0);
    // A tx_done during SEND, and a second word offered while busy
    valid = 1'b1;
    word  = 32'hCAFE_F00D;
    push_word(32'hCAFE_F00D);
    tx_done = 1'b1;
    tick();
    word = 32'h0BAD_BEEF;
    tick();
    tx_done = 1'b0;
    repeat (3) tick();
    valid = 1'b0;
    chk("ign_starts", 32'(start_cnt0 - s0), 32'd1);
    chk("ign_busy", 32'(busy0), 32'd1);
    chk("ign_data0", 32'(data0), 32'h0D);
    chk("ign_data1", 32'(data1), 32'hCA);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    run_bytes(3, 1);
    finish_word();
    chk("ign_total_starts", 32'(start_cnt0 - s0), 32'd4);
    chk("ign_dones", 32'(done_cnt0 - d0), 32'd1);

    // Abort together with a valid word while idle rejects the word
    s0 = start_cnt0;
    abort = 1'b1;
    valid = 1'b1;
    word  = 32'hFFFF_FFFF;
    tick();
    abort = 1'b0;
    valid = 1'b0;
    chk("rej_busy", 32'(busy0), 32'd0);
    chk("rej_start", 32'(start0), 32'd0);
    repeat (3) tick();
    chk("rej_starts", 32'(start_cnt0 - s0), 32'd0);

    // Abort coinciding with the second tx_done: abort wins
    s0 = start_cnt0; d0 = done_cnt0;
    send_word(32'hA1B2_C3D4);
    run_bytes(1, 1);
    wait_start();
    @(posedge clk);
    #1;
    tx_done = 1'b1;
    abort   = 1'b1;
    tick();
    tx_done = 1'b0;
    abort   = 1'b0;
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_ready", 32'(ready0), 32'd1);
    chk("abort_start", 32'(start0), 32'd0);
    repeat (5) tick();
    chk("abort_starts", 32'(start_cnt0 - s0), 32'd2);
    chk("abort_dones", 32'(done_cnt0 - d0), 32'd0);
    chk("abort_left0", 32'(q0.size()), 32'd2);
    chk("abort_left1", 32'(q1.size()), 32'd2);
    q0.delete();
    q1.delete();

    // Asynchronous reset in the middle of WAIT, then a fresh word
    send_word(32'h5566_7788);
    wait_start();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    chk("rst_left0", 32'(q0.size()), 32'd3);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s0 = start_cnt0; d0 = done_cnt0;
    send_word(32'h0000_0001);
    run_bytes(4, 1);
    finish_word();
    chk("post_rst_starts", 32'(start_cnt0 - s0), 32'd4);
    chk("post_rst_dones", 32'(done_cnt0 - d0), 32'd1);

    // Back-to-back words, tx_done 3 cycles after each start
    s0 = start_cnt0; d0 = done_cnt0;
    send_word(32'hAABB_CCDD);
    run_bytes(3, 3);
    wait_start();
    pulse_done(3);
    valid = 1'b1;
    word  = 32'h1122_3344;
    push_word(32'h1122_3344);
    chk("b2b_done", 32'(wdone0), 32'd1);
    chk("b2b_done_ready", 32'(ready0), 32'd0);
    tick();
    chk("b2b_idle_ready", 32'(ready0), 32'd1);
    chk("b2b_idle_start", 32'(start0), 32'd0);
    tick();
    valid = 1'b0;
    chk("b2b_accept_start", 32'(start0), 32'd1);
    chk("b2b_accept_busy", 32'(busy0), 32'd1);
    run_bytes(4, 3);
    finish_word();
    chk("b2b_starts", 32'(start_cnt0 - s0), 32'd8);
    chk("b2b_dones", 32'(done_cnt0 - d0), 32'd2);

    repeat (2) tick();
    chk("final_q0_empty", 32'(q0.size()), 32'd0);
    chk("final_q1_empty", 32'(q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
